instr_mem_loader: RTL
=====================

Name: instr_mem_loader

Overview:
- Writer side of the instruction memory. The single-cycle/multicycle CPU fetch path only reads word-addressed instruction storage, indexed by Address[9:2].
- This block takes a byte-serial program image, for example from a UART receiver, and assembles big-endian 32-bit words.
- It writes each word into the instruction RAM write port and holds the CPU in reset until a complete, checksum-valid image has been loaded.

Parameters:
DEPTH, 256, instruction memory depth in words; the maximum accepted word count.
BASE_ADDR, 32'h0000_0000, byte address of word 0. Must be word aligned.
TIMEOUT, 1_000_000, number of idle clk cycles allowed between bytes inside a frame before the frame is aborted.
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
rx_valid  input  1  rx_data holds a new byte this cycle. A byte is accepted on every cycle rx_valid=1; there is no backpressure.
rx_data  input  8  received byte.
mem_we  output  1  one-cycle instruction RAM write strobe.
mem_addr  output  32  byte address of the write, BASE_ADDR + 4*index.
mem_wdata  output  32  assembled instruction word.
cpu_hold  output  1  1 = CPU held in reset; 0 = run.
load_done  output  1  the last frame loaded successfully (sticky).
load_error  output  1  the last frame failed (sticky).
words_loaded  output  16  number of words written in the current or last frame.

Behaviour:
- Reset values:
  - mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - cpu_hold=1, load_done=0, load_error=0, words_loaded=0.
  - State = IDLE.
- Frame format:
  - SYNC_BYTE, then N[15:8], then N[7:0].
  - Then 4*N data bytes, most significant byte of each word first.
  - Then one checksum byte equal to the XOR of all data bytes.
- States and transitions:
  - IDLE: ignores every byte that is not SYNC_BYTE. On SYNC_BYTE, clear load_done, load_error, words_loaded, the checksum accumulator and the byte counter; set cpu_hold=1; go to LEN_HI.
  - LEN_HI: on a byte, latch N[15:8]; go to LEN_LO.
  - LEN_LO: on a byte, latch N[7:0].
    - If N > DEPTH, go to ERROR.
    - If N == 0, go to CHECK.
    - Otherwise go to DATA.
  - DATA:
    - Shift each byte into a 32-bit assembly register: word = {word[23:0], byte}.
    - XOR the byte into the checksum accumulator.
    - A 2-bit byte counter wraps 3→0.
    - On the 4th byte of a word, accepted in cycle k: in cycle k+1, mem_we=1 for exactly one cycle, mem_wdata = the assembled word, mem_addr = BASE_ADDR + 4*words_loaded (pre-increment value). words_loaded increments in that same cycle.
    - When words_loaded reaches N, go to CHECK.
  - CHECK: on a byte, compare it with the accumulator.
    - Match: the next cycle sets load_done=1 and cpu_hold=0; go to IDLE.
    - Mismatch: go to ERROR.
  - ERROR: load_error=1 and cpu_hold=1 from the cycle after entry; go to IDLE.
- Arithmetic and widths:
  - The word index is 16 bits.
  - mem_addr is computed as a 32-bit sum.
  - Addresses never exceed BASE_ADDR + 4*(DEPTH-1) because N ≤ DEPTH is enforced.
- Timeout:
  - An idle-cycle counter runs in LEN_HI, LEN_LO, DATA and CHECK.
  - It resets on every accepted byte.
  - Reaching TIMEOUT forces ERROR. Words already written stay in memory, but cpu_hold stays 1.
- Simultaneous events: a byte arriving in the same cycle as mem_we for the previous word is accepted normally. The write strobe and byte assembly are independent, so no byte is lost.
- Restart:
  - A SYNC_BYTE in IDLE after done or error starts a new frame and reasserts cpu_hold.
  - A SYNC_BYTE value inside DATA or CHECK is ordinary data.
- Reset mid-frame: asynchronous return to reset values. A write strobe pending for the next cycle is dropped. Memory contents are not modified by reset.

Decomposition:
- Shared package/header holds:
  - state encoding (IDLE, LEN_HI, LEN_LO, DATA, CHECK, ERROR);
  - SYNC_BYTE default;
  - the word-to-byte-address shift constant (2).
- One natural sub-module: loader_timeout_counter, an idle counter with a clear input and a terminal-count flag.
- All remaining logic stays in one module.

Test Plan:
- Single word. Send A5 00 01 20 04 2F 5B 50 → exactly one mem_we pulse with mem_addr=0x0 and mem_wdata=0x20042F5B; then load_done=1, cpu_hold=0, words_loaded=1.
- Bad checksum. Send the same frame with checksum 51 → no change to the written word, load_error=1, load_done=0, cpu_hold=1. A following valid frame clears load_error and sets load_done.
- Full program with gaps. Send a 12-word program with random 0–5 cycle gaps, including back-to-back bytes → 12 writes at 0x00..0x2C in order, with word 11 = 0x0800000B.
- Length checks. Count 0x0101 (257, DEPTH=256) → load_error right after the length bytes and no mem_we. Count 0x0000 followed by checksum 00 → load_done with no writes.
- Timeout. With TIMEOUT=16, stop after 6 data bytes → load_error 16 cycles after the last byte, 1 write issued, cpu_hold=1.
- Leading junk and reset. Send 00 FF 12 before A5 → junk ignored and the frame loads normally. Assert reset between the 2nd and 3rd byte of a word → all outputs return to reset values and no mem_we occurs.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the byte-serial instruction memory loader:
// FSM encoding, default frame marker and word-to-byte address helper.
package instr_mem_loader_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_HI = 3'd1;
    localparam logic [2:0] ST_LEN_LO = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;
    localparam logic [2:0] ST_ERROR  = 3'd5;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam int unsigned ADDR_SHIFT = 2;

    function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                   input logic [15:0] idx);
        return base + ({16'd0, idx} << ADDR_SHIFT);
    endfunction

endpackage

// File: rtl/instr_mem_loader_timeout_counter.sv
// Idle-cycle counter for the loader: counts enabled cycles since the last
// clear and flags the cycle in which the TIMEOUT-th idle cycle elapses.
module loader_timeout_counter #(
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count and terminal flag
    always_comb begin
        count_d = count_q;
        expired = 1'b0;
        if (clr) begin
            count_d = {CW{1'b0}};
        end else if (en) begin
            if (count_q == TERM) begin
                expired = 1'b1;
                count_d = {CW{1'b0}};
            end else begin
                count_d = count_q + CW'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-serial program image loader: parses SYNC/length/data/checksum frames,
// writes big-endian words to instruction RAM and holds the CPU until loaded.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 1_000_000,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    logic [2:0]  state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  csum_q, csum_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        load_done_q, load_done_d;
    logic        load_error_q, load_error_d;
    logic [15:0] words_loaded_q, words_loaded_d;

    logic        in_frame_s;
    logic        tmo_expired_s;
    logic [15:0] n_s;
    logic [31:0] next_word_s;

    assign in_frame_s = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                        (state_q == ST_DATA)   || (state_q == ST_CHECK);

    loader_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (reset),
        .clr     (rx_valid | ~in_frame_s),
        .en      (in_frame_s & ~rx_valid),
        .expired (tmo_expired_s)
    );

    // Frame parser, word assembly and status next-state logic
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        word_d         = word_q;
        csum_d         = csum_q;
        byte_cnt_d     = byte_cnt_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        cpu_hold_d     = cpu_hold_q;
        load_done_d    = load_done_q;
        load_error_d   = load_error_q;
        words_loaded_d = words_loaded_q;
        n_s            = {len_q[15:8], rx_data};
        next_word_s    = {word_q[23:0], rx_data};

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    load_done_d    = 1'b0;
                    load_error_d   = 1'b0;
                    words_loaded_d = 16'd0;
                    csum_d         = 8'h00;
                    byte_cnt_d     = 2'd0;
                    cpu_hold_d     = 1'b1;
                    state_d        = ST_LEN_HI;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LEN_HI: begin
                if (rx_valid) begin
                    len_d[15:8] = rx_data;
                    state_d     = ST_LEN_LO;
                end else if (tmo_expired_s) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_LO: begin
                if (rx_valid) begin
                    len_d = n_s;
                    if (n_s > 16'(DEPTH)) begin
                        state_d = ST_ERROR;
                    end else if (n_s == 16'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (tmo_expired_s) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_LEN_LO;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    word_d     = next_word_s;
                    csum_d     = csum_q ^ rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // Fourth byte completes a word: strobe it out next cycle
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d       = 1'b1;
                        mem_wdata_d    = next_word_s;
                        mem_addr_d     = word_byte_addr(BASE_ADDR, words_loaded_q);
                        words_loaded_d = words_loaded_q + 16'd1;
                        if ((words_loaded_q + 16'd1) == len_q) begin
                            state_d = ST_CHECK;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (tmo_expired_s) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_CHECK: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end else if (tmo_expired_s) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_ERROR: begin
                load_error_d = 1'b1;
                cpu_hold_d   = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            len_q          <= 16'd0;
            word_q         <= 32'd0;
            csum_q         <= 8'h00;
            byte_cnt_q     <= 2'd0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= BASE_ADDR;
            mem_wdata_q    <= 32'd0;
            cpu_hold_q     <= 1'b1;
            load_done_q    <= 1'b0;
            load_error_q   <= 1'b0;
            words_loaded_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            word_q         <= word_d;
            csum_q         <= csum_d;
            byte_cnt_q     <= byte_cnt_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            cpu_hold_q     <= cpu_hold_d;
            load_done_q    <= load_done_d;
            load_error_q   <= load_error_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;
    assign words_loaded = words_loaded_q;

endmodule
